// File: rtl/acdc_symbol_coder.sv
`default_nettype none
// ============================================================================
//  Module   : acdc_symbol_coder
//  Purpose  : Turns one block of quantised coefficients (index 0 = DC,
//             1..B-1 = AC in zigzag order) into a stream of
//             (run, size, amplitude) symbols. There is one differential DC
//             symbol, then run-length coded AC symbols with ZRL escapes and
//             an EOB marker. Each channel keeps its own DC predictor.
//  Ports    : clk, rst (async, active-low)
//             start/chan/val_array  - block request, sampled together
//             pred_clr              - zero all DC predictors (idle only)
//             busy, done            - block in progress / completion pulse
//             sym_valid/sym_ready   - symbol handshake
//             sym_dc, sym_run, sym_size, sym_amp, sym_last - symbol fields
//  Revision : 1.0 - initial release
// ============================================================================
module acdc_symbol_coder #(
   parameter int B   = 64,
   parameter int W   = 12,
   parameter int NCH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [$clog2(NCH)-1:0] chan,
   input  logic                   pred_clr,
   input  logic [B*W-1:0]         val_array,
   output logic                   busy,
   output logic                   sym_valid,
   input  logic                   sym_ready,
   output logic                   sym_dc,
   output logic [3:0]             sym_run,
   output logic [3:0]             sym_size,
   output logic [W-1:0]           sym_amp,
   output logic                   sym_last,
   output logic                   done
);

   localparam int              CW         = $clog2(NCH);
   localparam int              IW         = $clog2(B);
   localparam logic [IW-1:0]   c_idx_last = IW'(B - 1);
   localparam logic [W:0]      c_one      = (W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DC   = 3'd1,
      S_SCAN = 3'd2,
      S_EMIT = 3'd3,
      S_EOB  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t              r_state, w_next;
   logic signed [W-1:0] r_blk  [B];
   logic signed [W-1:0] r_pred [NCH];
   logic [CW-1:0]       r_chan;
   logic [IW-1:0]       r_idx;
   logic [5:0]          r_run;
   // pending symbol, produced by DC/SCAN/EOB and moved to the outputs in EMIT
   logic                r_p_dc, r_p_last;
   logic [3:0]          r_p_run, r_p_size;
   logic [W-1:0]        r_p_amp;
   // output symbol register
   logic                r_valid, r_dc, r_last;
   logic [3:0]          r_orun, r_size;
   logic [W-1:0]        r_amp;

   logic signed [W-1:0] w_pred, w_coef;
   logic signed [W:0]   w_dc_diff, w_ac_val;
   logic [3:0]          w_dc_size, w_ac_size;
   logic                w_coef_zero, w_at_end, w_load, w_accept;

   // bit length of |x|, 0 for x = 0
   function automatic logic [3:0] f_size(input logic signed [W:0] x);
      logic [W:0] mag;
      logic [3:0] s;
      s   = '0;
      mag = x[W] ? -x : x;
      for (int i = 0; i <= W; i++) begin
         if (mag[i]) s = 4'(i + 1);
      end
      return s;
   endfunction

   // negative values are sent as the low size bits of (x - 1)
   function automatic logic [W-1:0] f_amp(input logic signed [W:0] x,
                                          input logic [3:0] sz);
      logic [W:0] t, m;
      t = x[W] ? (x - c_one) : x;
      m = ({{W{1'b0}}, 1'b1} << sz) - c_one;
      return t[W-1:0] & m[W-1:0];
   endfunction

   always_comb begin
      w_pred = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_chan == CW'(i)) w_pred = r_pred[i];
      end
   end

   assign w_coef      = r_blk[r_idx];
   assign w_dc_diff   = {r_blk[0][W-1], r_blk[0]} - {w_pred[W-1], w_pred};
   assign w_ac_val    = {w_coef[W-1], w_coef};
   assign w_dc_size   = f_size(w_dc_diff);
   assign w_ac_size   = f_size(w_ac_val);
   assign w_coef_zero = (w_coef == '0);
   assign w_at_end    = (r_idx == c_idx_last);
   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_FIN));
   // the final symbol must drain before anything else is loaded
   assign w_load      = (r_state == S_EMIT) && !(r_valid && r_last)
                        && (!r_valid || sym_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = (r_state != S_IDLE) && (r_state != S_FIN);
      done   = (r_state == S_FIN);
      case (r_state)
         S_IDLE, S_FIN: w_next = start ? S_DC : S_IDLE;
         S_DC:          w_next = S_EMIT;
         S_SCAN: begin
            if (!w_coef_zero)  w_next = S_EMIT;
            else if (w_at_end) w_next = S_EOB;
         end
         S_EOB:         w_next = S_EMIT;
         S_EMIT: begin
            if (r_valid && r_last) begin
               if (sym_ready) w_next = S_FIN;
            end else if (w_load) begin
               w_next = r_p_last ? S_EMIT : S_SCAN;
            end
         end
         default:       w_next = S_IDLE;
      endcase
   end

   // block storage needs no reset: it is only read after a capture
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < B; i++) r_blk[i] <= val_array[i*W +: W];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) r_pred[i] <= '0;
         r_chan   <= '0;
         r_idx    <= '0;
         r_run    <= '0;
         r_p_dc   <= 1'b0;
         r_p_last <= 1'b0;
         r_p_run  <= '0;
         r_p_size <= '0;
         r_p_amp  <= '0;
         r_valid  <= 1'b0;
         r_dc     <= 1'b0;
         r_last   <= 1'b0;
         r_orun   <= '0;
         r_size   <= '0;
         r_amp    <= '0;
      end else begin
         // a transfer empties the output register unless EMIT refills it
         if (r_valid && sym_ready) r_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_FIN: begin
               // clearing at the capture edge means the DC diff sees pred = 0
               if (pred_clr) begin
                  for (int i = 0; i < NCH; i++) r_pred[i] <= '0;
               end
               if (start) begin
                  r_chan <= chan;
                  r_idx  <= IW'(1);
                  r_run  <= '0;
               end
            end
            S_DC: begin
               r_p_dc   <= 1'b1;
               r_p_last <= 1'b0;
               r_p_run  <= '0;
               r_p_size <= w_dc_size;
               r_p_amp  <= f_amp(w_dc_diff, w_dc_size);
               for (int i = 0; i < NCH; i++) begin
                  if (r_chan == CW'(i)) r_pred[i] <= r_blk[0];
               end
            end
            S_SCAN: begin
               if (w_coef_zero) begin
                  r_run <= r_run + 6'd1;
                  if (!w_at_end) r_idx <= r_idx + IW'(1);
               end else if (r_run >= 6'd16) begin
                  // ZRL escape; the same index is examined again afterwards
                  r_p_dc   <= 1'b0;
                  r_p_last <= 1'b0;
                  r_p_run  <= 4'd15;
                  r_p_size <= '0;
                  r_p_amp  <= '0;
                  r_run    <= r_run - 6'd16;
               end else begin
                  r_p_dc   <= 1'b0;
                  r_p_last <= w_at_end;
                  r_p_run  <= r_run[3:0];
                  r_p_size <= w_ac_size;
                  r_p_amp  <= f_amp(w_ac_val, w_ac_size);
                  r_run    <= '0;
                  if (!w_at_end) r_idx <= r_idx + IW'(1);
               end
            end
            S_EOB: begin
               r_p_dc   <= 1'b0;
               r_p_last <= 1'b1;
               r_p_run  <= '0;
               r_p_size <= '0;
               r_p_amp  <= '0;
            end
            S_EMIT: begin
               if (w_load) begin
                  r_valid <= 1'b1;
                  r_dc    <= r_p_dc;
                  r_last  <= r_p_last;
                  r_orun  <= r_p_run;
                  r_size  <= r_p_size;
                  r_amp   <= r_p_amp;
               end
            end
            default: ;
         endcase
      end
   end

   assign sym_valid = r_valid;
   assign sym_dc    = r_dc;
   assign sym_last  = r_last;
   assign sym_run   = r_orun;
   assign sym_size  = r_size;
   assign sym_amp   = r_amp;

endmodule
`default_nettype wire

// File: tb/tb_acdc_symbol_coder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acdc_symbol_coder
//  Purpose  : Directed bench for acdc_symbol_coder: reference block, DC
//             prediction across blocks and channels, ZRL/EOB handling,
//             backpressure with simultaneous predictor clear, and an
//             asynchronous reset in the middle of a block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acdc_symbol_coder;

   localparam int B   = 64;
   localparam int W   = 12;
   localparam int NCH = 3;

   logic           clk       = 1'b0;
   logic           rst       = 1'b1;
   logic           start     = 1'b0;
   logic           pred_clr  = 1'b0;
   logic           sym_ready = 1'b1;
   logic [1:0]     chan      = '0;
   logic [B*W-1:0] val_array = '0;
   logic           busy, sym_valid, sym_dc, sym_last, done;
   logic [3:0]     sym_run, sym_size;
   logic [W-1:0]   sym_amp;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   acdc_symbol_coder #(.B(B), .W(W), .NCH(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .chan      (chan),
      .pred_clr  (pred_clr),
      .val_array (val_array),
      .busy      (busy),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_dc    (sym_dc),
      .sym_run   (sym_run),
      .sym_size  (sym_size),
      .sym_amp   (sym_amp),
      .sym_last  (sym_last),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   // packed symbol: {dc, last, run, size, amp}
   function automatic logic [31:0] mk(input logic dc, input int run, input int size,
                                      input int amp, input logic last);
      return {10'b0, dc, last, 4'(run), 4'(size), 12'(amp)};
   endfunction

   function automatic logic [31:0] cur_sym();
      return {10'b0, sym_dc, sym_last, sym_run, sym_size, sym_amp};
   endfunction

   task automatic set_val(input int idx, input int v);
      val_array[idx*W +: W] = W'(v);
   endtask

   task automatic ref_block(input int v0);
      val_array = '0;
      set_val(0, v0);   set_val(3, -12); set_val(5, -16);
      set_val(10, -1);  set_val(12, 9);  set_val(14, -1);
      set_val(23, -1);  set_val(25, -1); set_val(39, 1);
   endtask

   task automatic push_ref_ac();
      exp_q.push_back(mk(0, 2, 4, 3, 0));
      exp_q.push_back(mk(0, 1, 5, 15, 0));
      exp_q.push_back(mk(0, 4, 1, 0, 0));
      exp_q.push_back(mk(0, 1, 4, 9, 0));
      exp_q.push_back(mk(0, 1, 1, 0, 0));
      exp_q.push_back(mk(0, 8, 1, 0, 0));
      exp_q.push_back(mk(0, 1, 1, 0, 0));
      exp_q.push_back(mk(0, 13, 1, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1));
   endtask

   // Runs one block and compares the transferred symbols against exp_q.
   // stall: cycles of sym_ready low while the first AC symbol is pending.
   // abort: pulse rst low right after this many transfers.
   task automatic run_block(input int ch, input logic clr, input int stall, input int abort);
      int          n        = 0;
      int          cyc      = 0;
      int          first    = -1;
      int          last_cyc = -1;
      int          st       = 0;
      logic [31:0] held     = '0;
      logic        fin      = 1'b0;
      sym_ready = 1'b1;
      @(negedge clk);
      chan = 2'(ch); start = 1'b1; pred_clr = clr;
      @(posedge clk);
      #1 start = 1'b0; pred_clr = 1'b0;
      while (!fin && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (sym_valid && first < 0) begin
            first = cyc;
            check("dc_latency", 32'(cyc), 32'd3);
         end
         sym_ready = 1'b1;
         if (stall > 0 && n == 1 && sym_valid && st < stall) begin
            sym_ready = 1'b0;
            if (st == 0) held = cur_sym();
            else         check("stall_hold", cur_sym(), held);
            st++;
         end
         if (done) begin
            check("done_after_last", 32'(cyc), 32'(last_cyc + 1));
            check("busy_at_done", 32'(busy), 32'd0);
            fin = 1'b1;
         end else if (sym_valid && sym_ready) begin
            check($sformatf("sym%0d", n), cur_sym(),
                  (n < exp_q.size()) ? exp_q[n] : 32'hdead_beef);
            if (sym_last) last_cyc = cyc;
            n++;
            if (abort > 0 && n == abort) begin
               @(posedge clk);
               #2 rst = 1'b0;
               #1;
               check("rst_busy", 32'(busy), 32'd0);
               check("rst_valid", 32'(sym_valid), 32'd0);
               check("rst_sym", cur_sym(), 32'd0);
               fin = 1'b1;
            end
         end
      end
      if (!fin) check("timeout", 32'd0, 32'd1);
      if (abort == 0) begin
         check("sym_count", 32'(n), 32'(exp_q.size()));
         @(negedge clk);
         check("done_width", 32'(done), 32'd0);
      end
      exp_q.delete();
   endtask

   initial begin
      // reset state
      #2 rst = 1'b0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(sym_valid), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sym", cur_sym(), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // reference block, chan 0, pred 0
      ref_block(-49);
      exp_q.push_back(mk(1, 0, 6, 14, 0));
      push_ref_ac();
      run_block(0, 1'b0, 0, 0);

      // prediction: pred0 = -49, diff = +16
      ref_block(-33);
      exp_q.push_back(mk(1, 0, 5, 16, 0));
      push_ref_ac();
      run_block(0, 1'b0, 0, 0);

      // chan 1 still has pred 0: diff = -33
      ref_block(-33);
      exp_q.push_back(mk(1, 0, 6, 30, 0));
      push_ref_ac();
      run_block(1, 1'b0, 0, 0);

      // ZRL before a nonzero, trailing zeros end with EOB
      val_array = '0;
      set_val(40, 5);
      exp_q.push_back(mk(1, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 15, 0, 0, 0));
      exp_q.push_back(mk(0, 15, 0, 0, 0));
      exp_q.push_back(mk(0, 7, 3, 5, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      run_block(2, 1'b0, 0, 0);

      // nonzero last coefficient: no EOB
      val_array = '0;
      set_val(63, 2);
      exp_q.push_back(mk(1, 0, 0, 0, 0));
      repeat (3) exp_q.push_back(mk(0, 15, 0, 0, 0));
      exp_q.push_back(mk(0, 14, 2, 2, 1));
      run_block(2, 1'b0, 0, 0);

      // pred_clr together with start (pred0 = -33 beforehand), plus backpressure
      ref_block(-49);
      exp_q.push_back(mk(1, 0, 6, 14, 0));
      push_ref_ac();
      run_block(0, 1'b1, 5, 0);

      // reset after the 3rd transfer; pred0 = -49 so the DC diff is 0 here
      ref_block(-49);
      exp_q.push_back(mk(1, 0, 0, 0, 0));
      push_ref_ac();
      run_block(0, 1'b0, 0, 3);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("no_stale_sym", 32'(sym_valid), 32'd0);
      end

      // predictor was cleared by reset
      ref_block(-49);
      exp_q.push_back(mk(1, 0, 6, 14, 0));
      push_ref_ac();
      run_block(0, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
